// File: rtl/pid_pwm_gen.sv
// PWM generator driven by a signed controller output, with period-aligned duty updates.
// Optional dead-time insertion on both drive rising edges is enabled by PID_PWM_DEADTIME_EN.
module pid_pwm_gen #(
    parameter int W        = 16,
    parameter int CNT_W    = 10,
    parameter int DEADTIME = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [W-1:0]     y_in,
    input  logic             y_valid,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_start,
    output logic             update_ack,
    output logic [CNT_W-1:0] duty_q
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [W-1:0]     MSB_BIT = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, duty_active, pending, duty_map;
    logic             pending_valid, load, raw_h, raw_l;

    // Flipping the sign bit turns two's complement into offset binary.
    assign duty_map = CNT_W'((y_in ^ MSB_BIT) >> (W - CNT_W));

    // load marks the edge that enters a cnt=0 RUN cycle, so the new duty
    // is already in force for the whole period it belongs to.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: if (enable) begin
                state_nxt = RUN;
                load      = 1'b1;
            end
            RUN: if (cnt == CNT_MAX) begin
                if (enable) load = 1'b1;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == RUN) ? cnt + 1'b1 : '0;
        end
    end

    // Load consumes the old pending value; a coincident y_valid refills it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_active   <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            update_ack    <= 1'b0;
        end else begin
            update_ack <= load & pending_valid;
            if (load && pending_valid) duty_active <= pending;
            if (y_valid) begin
                pending       <= duty_map;
                pending_valid <= 1'b1;
            end else if (load) begin
                pending_valid <= 1'b0;
            end
        end
    end

    assign period_start = (state == RUN) && (cnt == '0);
    assign duty_q       = duty_active;
    assign raw_h        = (state == RUN) && (cnt < duty_active);
    assign raw_l        = (state == RUN) && !(cnt < duty_active);

`ifdef PID_PWM_DEADTIME_EN
    localparam int DT_W = $clog2(DEADTIME + 1);

    logic [1:0]           raw, drv;
    logic [1:0][DT_W-1:0] dt_cnt;

    assign raw = {raw_h, raw_l};

    // A channel turns on only after its raw request has been held DEADTIME cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dt_cnt <= '0;
            drv    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!raw[i]) begin
                    dt_cnt[i] <= '0;
                    drv[i]    <= 1'b0;
                end else if (dt_cnt[i] == DT_W'(DEADTIME)) begin
                    drv[i]    <= 1'b1;
                end else begin
                    dt_cnt[i] <= dt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pwm_h = drv[1];
    assign pwm_l = drv[0];
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else begin
            pwm_h <= raw_h;
            pwm_l <= raw_l;
        end
    end
`endif

endmodule

// File: tb/tb_pid_pwm_gen.sv
// Randomized and directed bench for pid_pwm_gen (W=16, CNT_W=4, DEADTIME=2).
// Builds with or without PID_PWM_DEADTIME_EN; expectations follow the macro.
module tb_pid_pwm_gen;

    localparam int W = 16, CNT_W = 4, DT = 2, PERIOD = 16;
`ifdef PID_PWM_DEADTIME_EN
    localparam int NW = DT + 1;
    localparam bit DT_ON = 1'b1;
`else
    localparam int NW = 1;
    localparam bit DT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n, enable, y_valid;
    logic [W-1:0]     y_in;
    logic             pwm_h, pwm_l, period_start, update_ack;
    logic [CNT_W-1:0] duty_q;

    pid_pwm_gen #(.W(W), .CNT_W(CNT_W), .DEADTIME(DT)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .y_in(y_in), .y_valid(y_valid),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .period_start(period_start),
        .update_ack(update_ack), .duty_q(duty_q)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cnt_h, cnt_l, cnt_ps, cnt_ack;

    // Reference: period position, active/pending duty, and raw-drive history.
    bit m_run, m_pv, m_ack;
    int m_pos, m_duty, m_pend;
    bit hist_h[NW], hist_l[NW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int map_duty(input logic [W-1:0] y);
        return ((int'(y) + 32768) % 65536) / (65536 / PERIOD);
    endfunction

    task automatic model_reset();
        m_run = 0; m_pv = 0; m_ack = 0; m_pos = 0; m_duty = 0; m_pend = 0;
        for (int i = 0; i < NW; i++) begin
            hist_h[i] = 0;
            hist_l[i] = 0;
        end
    endtask

    task automatic step();
        bit rh, rl, ld, eh, el;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            rh = m_run && (m_pos < m_duty);
            rl = m_run && !(m_pos < m_duty);
            for (int i = NW - 1; i > 0; i--) begin
                hist_h[i] = hist_h[i-1];
                hist_l[i] = hist_l[i-1];
            end
            hist_h[0] = rh;
            hist_l[0] = rl;
            ld = 0;
            m_ack = 0;
            if (!m_run) begin
                if (enable) begin m_run = 1; m_pos = 0; ld = 1; end
            end else if (m_pos == PERIOD - 1) begin
                m_pos = 0;
                if (enable) ld = 1;
                else m_run = 0;
            end else begin
                m_pos++;
            end
            if (ld) begin
                m_ack = m_pv;
                if (m_pv) m_duty = m_pend;
                m_pv = 0;
            end
            if (y_valid) begin
                m_pend = map_duty(y_in);
                m_pv = 1;
            end
        end
        eh = 1; el = 1;
        for (int i = 0; i < NW; i++) begin
            eh &= hist_h[i];
            el &= hist_l[i];
        end
        #1;
        chk("pwm_h", 32'(pwm_h), 32'(eh));
        chk("pwm_l", 32'(pwm_l), 32'(el));
        chk("period_start", 32'(period_start), 32'(m_run && m_pos == 0));
        chk("update_ack", 32'(update_ack), 32'(m_ack));
        chk("duty_q", 32'(duty_q), 32'(m_duty));
        chk("no_overlap", 32'(pwm_h & pwm_l), 32'd0);
        cnt_h += int'(pwm_h);
        cnt_l += int'(pwm_l);
        cnt_ps += int'(period_start);
        cnt_ack += int'(update_ack);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        cnt_h = 0; cnt_l = 0; cnt_ps = 0; cnt_ack = 0;
    endtask

    // Pulse y_valid once, then wait (bounded) for the duty to go active.
    task automatic set_duty(input logic [W-1:0] y, input string tag);
        bit seen;
        y_in = y; y_valid = 1'b1;
        step();
        y_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
            step();
            if (m_ack) seen = 1;
        end
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_pos(input int p, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 3 * PERIOD && !hit; i++) begin
            step();
            if (m_run && m_pos == p) hit = 1;
        end
        chk({tag, "_wait_pos"}, 32'(hit), 32'd1);
    endtask

    task automatic window(input int exp_h, input int exp_l, input string tag);
        run(PERIOD);
        clear_counts();
        run(PERIOD);
        chk({tag, "_h_count"}, 32'(cnt_h), 32'(exp_h));
        chk({tag, "_l_count"}, 32'(cnt_l), 32'(exp_l));
    endtask

    initial begin
        model_reset();
        clear_counts();
        reset_n = 1'b0; enable = 1'b0; y_valid = 1'b0; y_in = '0;
        #1;
        chk("rst_pwm_h", 32'(pwm_h), 32'd0);
        chk("rst_duty_q", 32'(duty_q), 32'd0);
        run(3);
        reset_n = 1'b1;
        run(3);

        // Mid-scale input: duty 8, first update acknowledged at the first period start.
        y_in = 16'h0000; y_valid = 1'b1;
        step();
        y_valid = 1'b0; enable = 1'b1;
        step();
        chk("first_ps", 32'(period_start), 32'd1);
        chk("first_ack", 32'(update_ack), 32'd1);
        chk("first_duty", 32'(duty_q), 32'd8);
        window(DT_ON ? 6 : 8, DT_ON ? 6 : 8, "duty8");

        // Asynchronous reset mid-period clears everything without a clock edge.
        wait_pos(6, "rst");
        #3 reset_n = 1'b0;
        #1;
        chk("async_pwm_h", 32'(pwm_h), 32'd0);
        chk("async_pwm_l", 32'(pwm_l), 32'd0);
        chk("async_ps", 32'(period_start), 32'd0);
        chk("async_duty", 32'(duty_q), 32'd0);
        run(2);
        enable = 1'b0;
        reset_n = 1'b1;
        clear_counts();
        run(5);
        chk("post_rst_quiet", 32'(cnt_h + cnt_l + cnt_ps), 32'd0);
        enable = 1'b1;

        set_duty(16'h8000, "min");
        chk("min_duty", 32'(duty_q), 32'd0);
        window(0, DT_ON ? 16 : 16, "min");
        set_duty(16'h7FFF, "max");
        chk("max_duty", 32'(duty_q), 32'd15);
        window(DT_ON ? 13 : 15, DT_ON ? 0 : 1, "max");

        // Two updates in one period: last wins, one ack.
        wait_pos(2, "lastwin");
        y_in = 16'h4000; y_valid = 1'b1;
        step();
        y_in = 16'hC000;
        step();
        y_valid = 1'b0;
        chk("lastwin_hold", 32'(duty_q), 32'd15);
        clear_counts();
        run(PERIOD);
        chk("lastwin_acks", 32'(cnt_ack), 32'd1);
        chk("lastwin_duty", 32'(duty_q), 32'd4);

        // Enable dropped mid-period: finish the period, then stay idle.
        set_duty(16'h0000, "drop");
        wait_pos(5, "drop");
        enable = 1'b0;
        clear_counts();
        run(10);
        chk("drop_finish_ps", 32'(cnt_ps), 32'd0);
        chk("drop_last_h", 32'(cnt_h), 32'(DT_ON ? 3 : 3));
        clear_counts();
        run(20);
        chk("drop_idle_ps", 32'(cnt_ps), 32'd0);
        chk("drop_idle_out", 32'(pwm_h | pwm_l), 32'd0);

        // Random traffic against the reference model.
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            y_valid = ($urandom_range(0, 7) == 0);
            y_in = W'($urandom);
            if (i == 700) reset_n = 1'b0;
            if (i == 703) reset_n = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pid_pwm_gen.md
PID_PWM_GEN -- requirements
Module: pid_pwm_gen

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the signed controller-output width.
REQ-002 The block SHALL have parameter CNT_W, default 10, meaning the PWM counter width; period = 2^CNT_W cycles; legal range 2..W.
REQ-003 The block SHALL have parameter DEADTIME, default 8, meaning the dead-time in clk cycles; legal range 1..2^(CNT_W-1)-1.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-005 The block SHALL have port reset_n  input  1  meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port enable  input  1  meaning a level request to run PWM.
REQ-007 The block SHALL have port y_in  input  W  meaning the signed controller output, two's complement.
REQ-008 The block SHALL have port y_valid  input  1  meaning y_in is to be captured this cycle.
REQ-009 The block SHALL have port pwm_h  output  1  meaning the high-side drive.
REQ-010 The block SHALL have port pwm_l  output  1  meaning the low-side drive.
REQ-011 The block SHALL have port period_start  output  1  meaning a 1-cycle pulse on the first cycle of each PWM period.
REQ-012 The block SHALL have port update_ack  output  1  meaning a 1-cycle pulse when a pending duty becomes active.
REQ-013 The block SHALL have port duty_q  output  CNT_W  meaning the currently active duty.

Function
REQ-014 The block SHALL map y_in to duty by inverting its MSB (offset binary) and taking the top CNT_W bits: -2^(W-1)->0, 0->2^(CNT_W-1), 2^(W-1)-1->2^CNT_W-1.
REQ-015 The block SHALL register the mapped duty into a pending register on any cycle with y_valid=1 and set pending_valid; when several y_valid pulses occur within one period, the last one SHALL win.
REQ-016 The block SHALL implement the states IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE when cnt=2^CNT_W-1 and enable=0; otherwise it SHALL hold its state.
REQ-017 In IDLE the block SHALL hold cnt=0 and drive pwm_h=0, pwm_l=0, period_start=0.
REQ-018 In RUN, cnt SHALL increment by 1 each cycle and wrap from 2^CNT_W-1 to 0 with no skipped or repeated value.
REQ-019 On the cycle cnt=0 in RUN (including the first RUN cycle), period_start SHALL be 1; if pending_valid=1, the active duty SHALL take the pending value on that same edge, update_ack SHALL pulse, and pending_valid SHALL clear.
REQ-020 When y_valid coincides with a period-start load, the block SHALL load the old pending value and SHALL capture the new y_in as pending with pending_valid remaining set.
REQ-021 The block SHALL compute raw_h = (cnt < duty_active) and raw_l = !raw_h in RUN, and both = 0 in IDLE; pwm_h/pwm_l SHALL be registered, lagging raw by exactly 1 cycle.
REQ-022 With duty 0, pwm_h SHALL never be high; with duty 2^CNT_W-1, pwm_h SHALL be high 2^CNT_W-1 cycles per period.
REQ-023 When enable falls mid-period, the block SHALL complete the current period unchanged and then enter IDLE; if enable rises again before the period ends, the block SHALL not leave RUN.
REQ-024 pwm_h and pwm_l SHALL never be 1 in the same cycle.

Reset
REQ-025 Assertion of reset_n=0 SHALL immediately clear state to IDLE, cnt, duty_active, pending, pending_valid, dead-time counters, and all outputs to 0, including mid-period.
REQ-026 After reset_n deasserts, the first edge SHALL behave as from IDLE; no output SHALL glitch high during reset.

Configuration
REQ-027 With macro PID_PWM_DEADTIME_EN defined, each rising edge of registered pwm_h or pwm_l SHALL be delayed DEADTIME cycles after the corresponding raw rise, falling edges SHALL be undelayed, and a raw pulse no longer than DEADTIME SHALL produce no output pulse.
REQ-028 Without PID_PWM_DEADTIME_EN, no dead-time logic SHALL exist and pwm_l SHALL be the registered raw_l of REQ-021.

Verification (bench: W=16, CNT_W=4, DEADTIME=2)
REQ-029 The bench SHALL drive reset_n=0 mid-RUN with duty 8 -> all outputs 0 the same cycle, and after release, 0 until enable=1.
REQ-030 The bench SHALL drive y_in=0x0000 with y_valid and enable=1 -> update_ack at the first period_start, duty_q=8, and pwm_h high 8 of every 16 cycles (macro off).
REQ-031 The bench SHALL drive y_in=0x8000 and then 0x7FFF -> duty_q 0 with pwm_h never high, then duty_q 15 with pwm_h high 15/16 and pwm_l high 1/16.
REQ-032 The bench SHALL drive y_valid with 0x4000 and then 0xC000 in one period -> duty_q unchanged until the next period_start, which loads 4 (0xC000 wins), with one update_ack.
REQ-033 The bench SHALL drop enable at cnt=5 -> the period runs through cnt=15, then IDLE with outputs 0 and no further period_start.
REQ-034 The bench SHALL run with PID_PWM_DEADTIME_EN and duty 8 -> pwm_h high 6 cycles and pwm_l high 6 cycles per period, with 2-cycle gaps both low and never both high.
